// File: rtl/bottling_pkg.sv
// bottling_pkg: shared state encoding and default counter width for the bottling line.
package bottling_pkg;
  localparam int COUNT_W = 8;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_ADVANCE = 3'd2,
    S_PAUSE   = 3'd3,
    S_DONE    = 3'd4,
    S_FAULT   = 3'd5
  } state_e;
endpackage

// File: rtl/bottling_sequencer_watchdog_timer.sv
// watchdog_timer: counts running cycles since the last clear; expired marks the TIMEOUT_CYCLES-th.
module watchdog_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic clear,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt;
  // expired is raised while the edge about to happen would be the TIMEOUT_CYCLES-th quiet one
  assign expired = run && cnt == W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else if (clear || !run) cnt <= '0;
    else if (!expired) cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/bottling_sequencer.sv
// bottling_sequencer: fills bottles pill by pill, hands them to the conveyor and stops at the batch target.
module bottling_sequencer #(
  parameter int COUNT_W        = bottling_pkg::COUNT_W,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               working,
  input  logic [COUNT_W-1:0] pills_per_bottle,
  input  logic [COUNT_W-1:0] bottle_target,
  input  logic               pill_pulse,
  input  logic               conveyor_ready,
  output logic               gate_open,
  output logic               conveyor_advance,
  output logic [COUNT_W-1:0] pill_count,
  output logic [COUNT_W-1:0] bottle_count,
  output logic               done,
  output logic               fault
);
  import bottling_pkg::*;
  state_e state, next_state;
  logic [COUNT_W-1:0] ppb_latched, target_latched;
  logic expired, pill_done, bottle_done, run, clear;
  assign pill_done   = pill_pulse && (pill_count + COUNT_W'(1)) == ppb_latched;
  assign bottle_done = (bottle_count + COUNT_W'(1)) == target_latched;
  assign run         = state == S_FILL || state == S_ADVANCE;
  assign clear       = next_state != state || (state == S_FILL && pill_pulse);
  watchdog_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk(clk),
    .reset_n(reset_n),
    .run(run),
    .clear(clear),
    .expired(expired)
  );
  // a pill or a conveyor ack in the expiring cycle wins over the timeout
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (working) next_state = (pills_per_bottle == '0 || bottle_target == '0) ? S_FAULT : S_FILL;
      S_FILL:    next_state = pill_done ? S_ADVANCE : (expired && !pill_pulse) ? S_FAULT : !working ? S_PAUSE : S_FILL;
      S_ADVANCE: next_state = conveyor_ready ? (bottle_done ? S_DONE : working ? S_FILL : S_PAUSE) : expired ? S_FAULT : S_ADVANCE;
      S_PAUSE:   if (working) next_state = S_FILL;
      S_DONE:    if (!working) next_state = S_IDLE;
      S_FAULT:   if (!working) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      gate_open        <= 1'b0;
      conveyor_advance <= 1'b0;
      done             <= 1'b0;
      fault            <= 1'b0;
    end else begin
      state            <= next_state;
      gate_open        <= next_state == S_FILL;
      conveyor_advance <= next_state == S_ADVANCE;
      done             <= next_state == S_DONE;
      fault            <= next_state == S_FAULT;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ppb_latched    <= '0;
      target_latched <= '0;
      pill_count     <= '0;
      bottle_count   <= '0;
    end else if (state == S_IDLE && working) begin
      ppb_latched    <= pills_per_bottle;
      target_latched <= bottle_target;
      pill_count     <= '0;
      bottle_count   <= '0;
    end else if (state == S_FILL && pill_pulse) begin
      pill_count <= pill_count + COUNT_W'(1);
    end else if (state == S_ADVANCE && conveyor_ready) begin
      pill_count   <= '0;
      bottle_count <= bottle_count + COUNT_W'(1);
    end
  end
endmodule

// File: tb/tb_bottling_sequencer.sv
// tb_bottling_sequencer: directed scenarios plus random traffic checked against a behavioural batch model.
module tb_bottling_sequencer;
  localparam int W = 8;
  localparam int T = 10;
  logic clk = 1'b0;
  logic reset_n, working, pill_pulse, conveyor_ready;
  logic [W-1:0] ppb_in, tgt_in, pill_count, bottle_count;
  logic gate_open, conveyor_advance, done, fault;
  int n_cmp = 0, n_bad = 0;
  byte mode;
  int ppb_l, tgt_l, pc, bc, quiet;
  always #5 clk = ~clk;
  bottling_sequencer #(.COUNT_W(W), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .working(working),
    .pills_per_bottle(ppb_in),
    .bottle_target(tgt_in),
    .pill_pulse(pill_pulse),
    .conveyor_ready(conveyor_ready),
    .gate_open(gate_open),
    .conveyor_advance(conveyor_advance),
    .pill_count(pill_count),
    .bottle_count(bottle_count),
    .done(done),
    .fault(fault)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    mode = "I"; ppb_l = 0; tgt_l = 0; pc = 0; bc = 0; quiet = 0;
  endtask
  // mode letters: I idle, F filling, A awaiting conveyor, P paused, D done, X faulted
  task automatic model_step(input bit w, input bit p, input bit r);
    byte nm;
    nm = mode;
    case (mode)
      "I": if (w) begin
        ppb_l = int'(ppb_in); tgt_l = int'(tgt_in); pc = 0; bc = 0;
        nm = (ppb_l == 0 || tgt_l == 0) ? "X" : "F";
      end
      "F": begin
        if (p) begin
          pc++;
          if (pc == ppb_l) nm = "A";
        end
        if (nm == "F" && !p && quiet + 1 >= T) nm = "X";
        if (nm == "F" && !w) nm = "P";
      end
      "A": if (r) begin
        bc++; pc = 0;
        nm = (bc == tgt_l) ? "D" : w ? "F" : "P";
      end else if (quiet + 1 >= T) nm = "X";
      "P": if (w) nm = "F";
      "D", "X": if (!w) nm = "I";
      default: nm = "I";
    endcase
    if (nm != mode || (mode == "F" && p)) quiet = 0;
    else if (mode == "F" || mode == "A") quiet++;
    mode = nm;
  endtask
  task automatic compare_all();
    check("gate_open", gate_open, mode == "F");
    check("conveyor_advance", conveyor_advance, mode == "A");
    check("done", done, mode == "D");
    check("fault", fault, mode == "X");
    check("pill_count", pill_count, pc);
    check("bottle_count", bottle_count, bc);
  endtask
  task automatic cyc(input bit w, input bit p, input bit r);
    working = w; pill_pulse = p; conveyor_ready = r;
    @(posedge clk);
    model_step(w, p, r);
    #1;
    compare_all();
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_gate", gate_open, 0);
    check("rst_advance", conveyor_advance, 0);
    check("rst_counts", {pill_count, bottle_count}, 0);
    check("rst_flags", {done, fault}, 0);
    model_reset();
    working = 1'b0; pill_pulse = 1'b0; conveyor_ready = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask
  initial begin
    int pill_pct, rdy_pct, work_pct;
    reset_n = 1'b0; working = 1'b0; pill_pulse = 1'b0; conveyor_ready = 1'b0;
    ppb_in = '0; tgt_in = '0;
    model_reset();
    do_reset();
    // full batch of two bottles
    ppb_in = 3; tgt_in = 2;
    cyc(1, 0, 0);
    for (int b = 0; b < 2; b++) begin
      repeat (3) cyc(1, 1, 0);
      check("gate_after_fill", gate_open, 0);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      cyc(1, 0, 1);
      check("bottles_done", bottle_count, b + 1);
    end
    check("batch_done", done, 1);
    cyc(0, 0, 0);
    check("done_cleared", done, 0);
    // zero setting faults and keeps the gate shut
    ppb_in = 0; tgt_in = 2;
    cyc(1, 0, 0);
    check("zero_fault", fault, 1);
    repeat (3) cyc(1, 1, 0);
    check("zero_gate", gate_open, 0);
    cyc(0, 0, 0);
    check("zero_exit", fault, 0);
    // pause after the first pill, resume and complete the bottle
    ppb_in = 3; tgt_in = 1;
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    cyc(0, 0, 0);
    check("pause_gate", gate_open, 0);
    check("pause_hold", pill_count, 1);
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    check("resume_adv", conveyor_advance, 1);
    cyc(1, 0, 1);
    cyc(0, 0, 0);
    // pill and pause in the same cycle
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    check("pill_pause_cnt", pill_count, 1);
    check("pill_pause_gate", gate_open, 0);
    do_reset();
    // conveyor never answers
    ppb_in = 1; tgt_in = 2;
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    repeat (T - 1) cyc(1, 0, 0);
    check("pre_timeout", fault, 0);
    cyc(1, 0, 0);
    check("timeout_fault", fault, 1);
    check("timeout_adv", conveyor_advance, 0);
    cyc(0, 0, 0);
    // reset while waiting on the conveyor
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    check("pre_reset_adv", conveyor_advance, 1);
    do_reset();
    cyc(0, 1, 0);
    check("post_reset_pill", pill_count, 0);
    // random traffic in segments with varying pill/ack/run rates
    for (int s = 0; s < 40; s++) begin
      pill_pct = (s % 3 == 0) ? 0 : (s % 3 == 1) ? 20 : 60;
      rdy_pct  = (s % 4 == 0) ? 0 : (s % 4 == 1) ? 15 : 50;
      work_pct = 80 + int'($urandom_range(0, 20));
      if ($urandom_range(0, 9) == 0) do_reset();
      for (int i = 0; i < 100; i++) begin
        ppb_in = W'($urandom_range(0, 5));
        tgt_in = W'($urandom_range(0, 4));
        cyc($urandom_range(0, 99) < work_pct,
            $urandom_range(0, 99) < pill_pct,
            $urandom_range(0, 99) < rdy_pct);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
